// File: rtl/controle_vez.sv
// controle_vez: tic-tac-toe turn sequencer; validates a move, writes the board once, checks win/draw, passes or skips the turn
// Ports: clock, reset (synchronous, active-low)
//   iniciar                  start/restart a game (only from OCIOSO or FIM)
//   jogar, posicao           one-cycle move strobe and the cell 0..8 it targets
//   casa_ocupada, vitoria    feedback from the board (cell pos_reg taken) and the win detector
//   jogador                  player on turn, drives the player display
//   registra, pos_reg        board write enable (one cycle per accepted move) and latched cell
//   erro_jogada, estourou    one-cycle pulses: rejected move, turn timed out
//   num_jogadas              moves written this game (0..9)
//   fim_jogo, empate, vencedor  game over level, draw flag, winning player
//   estado                   FSM state code for debug display
module controle_vez #(
  parameter int TIMEOUT = 5000,
  parameter int W_TIMER = 13,
  parameter bit JOGADOR_INICIAL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogar,
  input  logic [3:0] posicao,
  input  logic       casa_ocupada,
  input  logic       vitoria,
  output logic       jogador,
  output logic       registra,
  output logic [3:0] pos_reg,
  output logic       erro_jogada,
  output logic       estourou,
  output logic [3:0] num_jogadas,
  output logic       fim_jogo,
  output logic       empate,
  output logic       vencedor,
  output logic [2:0] estado
);
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESPERA   = 3'd1,
    VALIDA   = 3'd2,
    REGISTRA = 3'd3,
    VERIFICA = 3'd4,
    TROCA    = 3'd5,
    FIM      = 3'd6
  } estado_t;
  localparam logic [W_TIMER-1:0] ULTIMO = W_TIMER'(TIMEOUT - 1);
  estado_t state, state_n;
  logic [W_TIMER-1:0] timer, timer_n;
  logic [3:0] pos_n, num_n;
  logic jogador_n, erro_n, estourou_n, empate_n, vencedor_n;
  always_comb begin
    state_n = state;
    timer_n = timer;
    pos_n = pos_reg;
    num_n = num_jogadas;
    jogador_n = jogador;
    erro_n = 1'b0;
    estourou_n = 1'b0;
    empate_n = empate;
    vencedor_n = vencedor;
    case (state)
      OCIOSO, FIM:
        if (iniciar) begin
          state_n = ESPERA;
          timer_n = '0;
          num_n = '0;
          empate_n = 1'b0;
          vencedor_n = 1'b0;
          jogador_n = JOGADOR_INICIAL;
        end
      // a move on the last allowed cycle still counts; the timer only runs while the player idles
      ESPERA:
        if (jogar) begin
          pos_n = posicao;
          state_n = VALIDA;
        end else if (timer == ULTIMO) begin
          estourou_n = 1'b1;
          state_n = TROCA;
        end else timer_n = timer + 1'b1;
      // rejected moves keep the running timer so retries cannot stretch the turn
      VALIDA:
        if (pos_reg > 4'd8 || casa_ocupada) begin
          erro_n = 1'b1;
          state_n = ESPERA;
        end else state_n = REGISTRA;
      REGISTRA: begin
        num_n = (num_jogadas < 4'd9) ? num_jogadas + 4'd1 : num_jogadas;
        state_n = VERIFICA;
      end
      // a win on the ninth move is a win, not a draw
      VERIFICA:
        if (vitoria) begin
          vencedor_n = jogador;
          state_n = FIM;
        end else if (num_jogadas == 4'd9) begin
          empate_n = 1'b1;
          state_n = FIM;
        end else state_n = TROCA;
      TROCA: begin
        jogador_n = ~jogador;
        timer_n = '0;
        state_n = ESPERA;
      end
      default: state_n = OCIOSO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= OCIOSO;
      timer <= '0;
      pos_reg <= '0;
      num_jogadas <= '0;
      jogador <= JOGADOR_INICIAL;
      erro_jogada <= 1'b0;
      estourou <= 1'b0;
      empate <= 1'b0;
      vencedor <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pos_reg <= pos_n;
      num_jogadas <= num_n;
      jogador <= jogador_n;
      erro_jogada <= erro_n;
      estourou <= estourou_n;
      empate <= empate_n;
      vencedor <= vencedor_n;
    end
  end
  assign registra = (state == REGISTRA);
  assign fim_jogo = (state == FIM);
  assign estado = state;
endmodule

// File: tb/tb_controle_vez.sv
// tb_controle_vez: randomized games against a turn/board reference model with an event scoreboard
module tb_controle_vez;
  localparam int TIMEOUT = 8;
  localparam int EV_REG = 0, EV_ERR = 1, EV_TO = 2, EV_END = 3, EV_GO = 4;
  logic clock = 1'b0;
  logic reset, iniciar, jogar, casa_ocupada, vitoria;
  logic [3:0] posicao;
  logic jogador, registra, erro_jogada, estourou, fim_jogo, empate, vencedor;
  logic [3:0] pos_reg, num_jogadas;
  logic [2:0] estado;
  controle_vez #(.TIMEOUT(TIMEOUT), .W_TIMER(4), .JOGADOR_INICIAL(1'b0)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogar(jogar), .posicao(posicao),
    .casa_ocupada(casa_ocupada), .vitoria(vitoria), .jogador(jogador), .registra(registra),
    .pos_reg(pos_reg), .erro_jogada(erro_jogada), .estourou(estourou), .num_jogadas(num_jogadas),
    .fim_jogo(fim_jogo), .empate(empate), .vencedor(vencedor), .estado(estado)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int lines [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 3, 6, 1, 4, 7, 2, 5, 8, 0, 4, 8, 2, 4, 6};
  function automatic bit has_line(input logic [31:0] b, input logic [1:0] m);
    bit r = 1'b0;
    for (int l = 0; l < 8; l++)
      if (b[2*lines[3*l]+:2] == m && b[2*lines[3*l+1]+:2] == m && b[2*lines[3*l+2]+:2] == m) r = 1'b1;
    return r;
  endfunction
  // board register file and win detector around the DUT (2 bits per cell: 0 empty, 1 player 1, 2 player 2)
  logic [31:0] env;
  always @(posedge clock)
    if (!reset || iniciar) env <= '0;
    else if (registra) env[2*pos_reg+:2] <= jogador ? 2'd2 : 2'd1;
  assign casa_ocupada = (pos_reg < 4'd9) && (env[2*pos_reg+:2] != 2'd0);
  always_comb vitoria = has_line(env, jogador ? 2'd2 : 2'd1);
  typedef struct {
    int kind;
    int cy;
    int a;
    int b;
    int c;
  } ev_t;
  ev_t q[$];
  int n_chk = 0, n_fail = 0;
  bit want_idle = 1'b0, done = 1'b0;
  task automatic push(input int k, input int cy, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.cy = cy; e.a = a; e.b = b; e.c = c;
    q.push_back(e);
  endtask
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic take(input int k);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", k, cyc);
      return;
    end
    e = q.pop_front();
    chk("event_kind", k, e.kind);
    chk("event_cycle", cyc, e.cy);
    chk("num_jogadas", num_jogadas, e.b);
    chk("jogador", jogador, e.c);
    if (k == EV_REG) chk("pos_reg", pos_reg, e.a);
    if (k == EV_END) begin
      chk("empate", empate, e.a);
      if (e.a == 0) chk("vencedor", vencedor, e.c);
    end
    if (k == EV_GO) chk("empate_cleared", empate, 0);
  endtask
  // monitor: pops the scoreboard whenever the DUT shows an event, plus reset-state probes
  initial begin
    bit prev_fim = 1'b0;
    forever begin
      @(negedge clock);
      if (registra) take(EV_REG);
      if (erro_jogada) take(EV_ERR);
      if (estourou) take(EV_TO);
      if (fim_jogo && !prev_fim) take(EV_END);
      if (!fim_jogo && prev_fim) take(EV_GO);
      prev_fim = fim_jogo;
      if (want_idle) begin
        chk("idle_estado", estado, 0);
        chk("idle_jogador", jogador, 0);
        chk("idle_registra", registra, 0);
        chk("idle_num_jogadas", num_jogadas, 0);
        chk("idle_fim_jogo", fim_jogo, 0);
        chk("idle_pulses", {erro_jogada, estourou, empate, vencedor}, 0);
      end
      if (cyc > 60000) begin
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: cycle %0d, limit 60000", cyc);
        done = 1'b1;
      end
      if (done) begin
        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end
  // reference model: board, player on turn, moves made and idle cycles spent this turn
  logic [31:0] mb;
  int player, moves, idle;
  bit over, in_fim;
  int seq_q[$];
  task automatic tick(input bit j, input int p, input bit ini);
    jogar = j;
    posicao = 4'(p);
    iniciar = ini;
    @(posedge clock);
    #1;
    jogar = 1'b0;
    iniciar = 1'b0;
  endtask
  task automatic start_game();
    if (in_fim) push(EV_GO, cyc + 1, 0, 0, 0);
    mb = '0; player = 0; moves = 0; idle = 0; over = 0; in_fim = 0;
    tick(0, 0, 1);
  endtask
  // the TIMEOUT-th idle cycle of a turn skips it
  task automatic idle_edge();
    if (idle == TIMEOUT - 1) begin
      push(EV_TO, cyc + 1, 0, moves, player);
      tick(0, 0, 0);
      tick(0, 0, 0);
      player ^= 1;
      idle = 0;
    end else begin
      tick(0, 0, 0);
      idle++;
    end
  endtask
  task automatic move(input int p);
    int c = cyc;
    if (p > 8 || mb[2*p+:2] != 2'd0) begin
      push(EV_ERR, c + 2, 0, moves, player);
      tick(1, p, 0);
      tick(0, 0, 0);
    end else begin
      push(EV_REG, c + 2, p, moves, player);
      mb[2*p+:2] = player ? 2'd2 : 2'd1;
      moves++;
      tick(1, p, 0);
      repeat (3) tick(0, 0, 0);
      if (has_line(mb, player ? 2'd2 : 2'd1) || moves == 9) begin
        push(EV_END, c + 4, has_line(mb, player ? 2'd2 : 2'd1) ? 0 : 1, moves, player);
        over = 1;
        in_fim = 1;
      end else begin
        tick(0, 0, 0);
        player ^= 1;
        idle = 0;
      end
    end
  endtask
  task automatic turn_step();
    int r = $urandom_range(0, 7);
    int d = (r == 0) ? TIMEOUT + $urandom_range(0, 3) : (r < 3) ? TIMEOUT - 1 - idle : $urandom_range(0, 3);
    repeat (d) idle_edge();
    move(($urandom_range(0, 9) < 7) ? $urandom_range(0, 8) : $urandom_range(9, 15));
  endtask
  task automatic play_seq();
    start_game();
    foreach (seq_q[i]) if (!over) move(seq_q[i]);
  endtask
  task automatic finish_game();
    while (!over) turn_step();
    repeat (3) tick(1, $urandom_range(0, 8), 0);
  endtask
  initial begin
    reset = 1'b0; iniciar = 1'b0; jogar = 1'b0; posicao = 4'd0;
    over = 0; in_fim = 0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    want_idle = 1'b1;
    tick(0, 0, 0);
    want_idle = 1'b0;
    reset = 1'b1;
    tick(0, 0, 0);
    seq_q = {4, 4, 11, 0, 3, 1, 4, 2};
    play_seq();
    finish_game();
    seq_q = {0, 1, 2, 4, 3, 5, 7, 6, 8};
    play_seq();
    finish_game();
    start_game();
    repeat (TIMEOUT) idle_edge();
    repeat (TIMEOUT - 1) idle_edge();
    move(4);
    finish_game();
    repeat (25) begin
      start_game();
      finish_game();
    end
    start_game();
    push(EV_REG, cyc + 2, 4, 0, 0);
    tick(1, 4, 0);
    tick(0, 0, 0);
    reset = 1'b0;
    tick(0, 0, 0);
    reset = 1'b1;
    want_idle = 1'b1;
    tick(0, 0, 0);
    want_idle = 1'b0;
    repeat (2) tick(0, 0, 0);
    done = 1'b1;
  end
endmodule
